// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between the rs and slb result producers.
// Each producer owns a one-entry holding slot; one full slot per cycle is broadcast on a registered CDB.
module cdb_arbiter #(
    parameter int DataWidth = 32,
    parameter int PcWidth   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_exception_from_rob,
    input  logic                 is_ready_from_rs,
    input  logic [PcWidth-1:0]   pc_from_rs,
    input  logic [DataWidth-1:0] data_from_rs,
    output logic                 is_ready_to_rs,
    input  logic                 is_ready_from_slb,
    input  logic [PcWidth-1:0]   pc_from_slb,
    input  logic [DataWidth-1:0] data_from_slb,
    output logic                 is_ready_to_slb,
    output logic                 is_valid_to_cdb,
    output logic [PcWidth-1:0]   pc_to_cdb,
    output logic [DataWidth-1:0] data_to_cdb,
    output logic                 is_busy
);

    typedef enum logic {
        PTR_RS  = 1'b0,
        PTR_SLB = 1'b1
    } ptr_t;

    ptr_t                 r_ptr;
    logic                 r_fullRs;
    logic [PcWidth-1:0]   r_pcRs;
    logic [DataWidth-1:0] r_dataRs;
    logic                 r_fullSlb;
    logic [PcWidth-1:0]   r_pcSlb;
    logic [DataWidth-1:0] r_dataSlb;
    logic                 r_valid;
    logic [PcWidth-1:0]   r_pc;
    logic [DataWidth-1:0] r_data;

    logic w_grantRs;
    logic w_grantSlb;
    logic w_acceptRs;
    logic w_acceptSlb;

    // The pointer only breaks ties when both slots hold a result.
    assign w_grantRs  = r_fullRs  & (~r_fullSlb | (r_ptr == PTR_RS));
    assign w_grantSlb = r_fullSlb & (~r_fullRs  | (r_ptr == PTR_SLB));

    assign is_ready_to_rs  = rst & (~r_fullRs  | w_grantRs);
    assign is_ready_to_slb = rst & (~r_fullSlb | w_grantSlb);

    // A zero tag means "no producer", so such a request never occupies a slot.
    assign w_acceptRs  = is_ready_from_rs  & is_ready_to_rs  & (pc_from_rs  != '0);
    assign w_acceptSlb = is_ready_from_slb & is_ready_to_slb & (pc_from_slb != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= PTR_RS;
            r_fullRs  <= 1'b0;
            r_pcRs    <= '0;
            r_dataRs  <= '0;
            r_fullSlb <= 1'b0;
            r_pcSlb   <= '0;
            r_dataSlb <= '0;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_data    <= '0;
        end else if (is_exception_from_rob) begin
            r_ptr     <= PTR_RS;
            r_fullRs  <= 1'b0;
            r_fullSlb <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_grantRs | w_grantSlb;
            if (w_grantRs) begin
                r_pc  <= r_pcRs;
                r_data <= r_dataRs;
                r_ptr <= PTR_SLB;
            end else if (w_grantSlb) begin
                r_pc  <= r_pcSlb;
                r_data <= r_dataSlb;
                r_ptr <= PTR_RS;
            end

            // A granted slot drains this edge unless it is refilled at the same time.
            if (w_acceptRs) begin
                r_fullRs <= 1'b1;
                r_pcRs   <= pc_from_rs;
                r_dataRs <= data_from_rs;
            end else if (w_grantRs) begin
                r_fullRs <= 1'b0;
            end

            if (w_acceptSlb) begin
                r_fullSlb <= 1'b1;
                r_pcSlb   <= pc_from_slb;
                r_dataSlb <= data_from_slb;
            end else if (w_grantSlb) begin
                r_fullSlb <= 1'b0;
            end
        end
    end

    assign is_valid_to_cdb = r_valid;
    assign pc_to_cdb       = r_pc;
    assign data_to_cdb     = r_data;
    assign is_busy         = r_fullRs | r_fullSlb | r_valid;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the ALU reservation station (rs) and the store/load buffer (slb).
- Each producer has a one-entry holding slot. A round-robin arbiter grants one full slot per cycle onto a registered CDB broadcast of (pc tag, data).
- The ROB, rs, slb and register-file rename logic consume the broadcast. A tag matching a RegQueue/q1/q2 entry wakes that dependency.
- A ROB exception flushes all in-flight results.

Parameters:
- DataWidth, 32, width of result data.
- PcWidth, 32, width of pc tag. Tag value 0 means "no producer".

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- is_exception_from_rob  input  1  flush request.
- is_ready_from_rs  input  1  rs presents a result this cycle.
- pc_from_rs  input  PcWidth  rs result tag.
- data_from_rs  input  DataWidth  rs result value.
- is_ready_to_rs  output  1  rs slot can accept this cycle.
- is_ready_from_slb  input  1  slb presents a result this cycle.
- pc_from_slb  input  PcWidth  slb result tag.
- data_from_slb  input  DataWidth  slb result value.
- is_ready_to_slb  output  1  slb slot can accept this cycle.
- is_valid_to_cdb  output  1  broadcast valid, registered.
- pc_to_cdb  output  PcWidth  broadcast tag, registered.
- data_to_cdb  output  DataWidth  broadcast data, registered.
- is_busy  output  1  at least one slot full, or broadcast valid.

Behaviour:
- Reset (rst low, async):
  - Slots empty; is_valid_to_cdb=0, pc_to_cdb=0, data_to_cdb=0; is_busy=0.
  - Priority pointer = rs.
  - is_ready_to_rs = is_ready_to_slb = 0 while rst is low.
  - Reset released mid-transfer: all prior results are lost. No broadcast occurs until a new request arrives.
- Per-slot state: full flag, pc, data.
- Grant (combinational, from slot full flags and pointer):
  - Only one slot full: that slot is granted.
  - Both full: the slot named by the pointer is granted.
  - Neither full: no grant.
- Ready: is_ready_to_X = ~full_X | grant_X. A granted slot can be refilled in the same cycle.
- Accept: at a clock edge, if is_ready_from_X & is_ready_to_X, the slot loads pc/data and full_X=1.
  - A request with pc_from_X==0 is discarded. Ready is unaffected and the slot does not fill.
- Broadcast:
  - At the edge where X is granted: pc_to_cdb/data_to_cdb load slot X, is_valid_to_cdb=1, and full_X clears unless refilled by the same edge.
  - With no grant: is_valid_to_cdb=0. pc_to_cdb and data_to_cdb hold their last values.
  - Latency: request at edge N, broadcast visible after edge N+1 (2 edges). Throughput: 1 result per cycle total.
- Round-robin: after granting rs the pointer moves to slb; after granting slb it moves to rs. It is unchanged with no grant.
  - Both requesters streaming every cycle therefore alternate rs, slb, rs, ...
- Flush: is_exception_from_rob high at an edge:
  - Both slots are cleared and is_valid_to_cdb=0 at that edge.
  - Requests presented in that cycle are dropped.
  - The pointer resets to rs.
  - Flush has priority over accept and grant.
- is_busy = full_rs | full_slb | is_valid_to_cdb.
- Requesters hold pc/data only in the cycle they assert ready. The arbiter never relies on inputs being held.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> all outputs 0 during reset; after release is_ready_to_rs=1 and is_ready_to_slb=1, is_valid_to_cdb=0.
- Single rs result pc=0x10, data=0x5 at edge 1 -> after edge 2 is_valid_to_cdb=1, pc_to_cdb=0x10, data_to_cdb=0x5; after edge 3 is_valid_to_cdb=0.
- Simultaneous requests, rs pc=0x20/data=1 and slb pc=0x24/data=2, at edge 1 -> edge 2 broadcasts 0x20 and is_ready_to_slb=0; edge 3 broadcasts 0x24.
- Both requesters stream 4 results each, one per cycle, while ready -> CDB order alternates rs, slb, rs, slb with no valid gaps; each requester is stalled every other cycle.
- slb slot full (pc=0x30) and is_exception_from_rob=1 at the next edge with rs pc=0x34 presented -> no broadcast of 0x30 or 0x34, slots empty, is_busy=0 next cycle.
- rs request with pc=0, data=0xFF -> is_ready_to_rs stays 1, no broadcast, is_busy stays 0.
